// File: rtl/keypad_scanner_if.sv
// Keypad matrix and key-code signal bundle.
// The scanner owns the master side: it senses rows and drives columns plus
// the accepted-key outputs. The slave side belongs to the matrix and consumer.
interface keypad_scanner_if;
  logic [3:0] row_sense;   // active-low rows, pulled up, asynchronous to clk
  logic [3:0] col_drive;   // active-low columns, exactly one low at a time
  logic [3:0] keypad;      // accepted key {row, col} or the idle code
  logic       key_valid;   // one-cycle pulse when a new key is accepted
  logic       key_held;    // high while the accepted key is down

  modport master (
    input  row_sense,
    output col_drive,
    output keypad,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_sense,
    input  col_drive,
    input  keypad,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press and release debouncing.
// Columns are walked one at a time. A low row at the end of a column dwell
// starts a press debounce on that single {row, col} crosspoint. Once a key
// is accepted, only that crosspoint is watched until its release is debounced.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 100,
  parameter int unsigned DEBOUNCE_CNT = 1000,
  parameter logic [3:0]  IDLE_CODE    = 4'b0000
) (
  input logic              clk,
  input logic              rst_n,
  keypad_scanner_if.master kp
);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DEB_TERM   = 16'(DEBOUNCE_CNT);

  // Column drive pattern for a column index: that column low, others high.
  function automatic logic [3:0] col_mask(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  // Lowest-indexed low row; only meaningful when at least one row is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    return r;
  endfunction

  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  state_t      state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [1:0]  row_q, row_d;
  logic [15:0] dwell_q, dwell_d;
  logic [15:0] deb_q, deb_d;
  logic [3:0]  col_drive_q, col_drive_d;
  logic [3:0]  keypad_q, keypad_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;

  logic [3:0]  row_s;
  logic        row_hit;
  logic [1:0]  col_next;
  logic [15:0] deb_inc;

  assign row_s    = sync2_q;
  assign row_hit  = ~row_s[row_q];
  assign col_next = col_q + 2'd1;
  assign deb_inc  = (deb_q >= DEB_TERM) ? deb_q : deb_q + 16'd1;

  // Next-state logic: scanning, debouncing and registered output updates.
  always_comb begin
    sync1_d     = kp.row_sense;
    sync2_d     = sync1_q;
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    col_drive_d = col_drive_q;
    keypad_d    = keypad_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      SCAN: begin
        if (dwell_q >= DWELL_LAST) begin
          if (row_s == 4'b1111) begin
            col_d       = col_next;
            dwell_d     = 16'd0;
            col_drive_d = col_mask(col_next);
          end else begin
            // Column stays driven; lowest row wins on multiple presses.
            row_d   = lowest_low(row_s);
            deb_d   = 16'd0;
            state_d = PRESS_DB;
          end
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end

      PRESS_DB: begin
        if (row_hit) begin
          deb_d = deb_inc;
          if (deb_inc == DEB_TERM) begin
            state_d     = PRESSED;
            keypad_d    = {row_q, col_q};
            key_held_d  = 1'b1;
            key_valid_d = 1'b1;
          end
        end else begin
          // Bounce: give up on this key and resume on the next column.
          state_d     = SCAN;
          col_d       = col_next;
          dwell_d     = 16'd0;
          col_drive_d = col_mask(col_next);
        end
      end

      PRESSED: begin
        if (!row_hit) begin
          deb_d   = 16'd0;
          state_d = RELEASE_DB;
        end
      end

      RELEASE_DB: begin
        if (row_hit) begin
          state_d = PRESSED;
        end else begin
          deb_d = deb_inc;
          if (deb_inc == DEB_TERM) begin
            state_d     = SCAN;
            keypad_d    = IDLE_CODE;
            key_held_d  = 1'b0;
            col_d       = col_next;
            dwell_d     = 16'd0;
            col_drive_d = col_mask(col_next);
          end
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase
  end

  // State and output registers; reset discards any press in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      dwell_q     <= 16'd0;
      deb_q       <= 16'd0;
      col_drive_q <= 4'b1110;
      keypad_q    <= IDLE_CODE;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      col_drive_q <= col_drive_d;
      keypad_q    <= keypad_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.col_drive = col_drive_q;
  assign kp.keypad    = keypad_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SCAN_DIV, default 100: clock cycles each column is driven before the scan advances; legal range 2..65535.
REQ-002 DEBOUNCE_CNT, default 1000: consecutive stable cycles required to accept a press or a release; legal range 1..65535.
REQ-003 IDLE_CODE, default 4'b0000: value presented on keypad when no key is accepted.
REQ-004 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 row_sense  input  4  keypad matrix rows; active-low, externally pulled up, asynchronous to clk.
REQ-007 col_drive  output  4  keypad matrix columns; active-low, exactly one bit low outside reset.
REQ-008 keypad  output  4  accepted key code {row[1:0], col[1:0]}, or IDLE_CODE; drives the security controller keypad input.
REQ-009 key_valid  output  1  one-cycle pulse on acceptance of a new key.
REQ-010 key_held  output  1  high from acceptance until the release is accepted.

Function
REQ-011 row_sense SHALL pass through a two-flop synchronizer; all decisions use the synchronized value row_s.
REQ-012 The FSM SHALL have exactly four states: SCAN, PRESS_DB, PRESSED, RELEASE_DB.
REQ-013 SCAN: drive column c low (col_drive = ~(4'b0001 << c)); dwell counter counts 0..SCAN_DIV-1; at count SCAN_DIV-1, if row_s == 4'b1111, c advances to (c+1) mod 4 and the dwell counter clears (3 wraps to 0).
REQ-014 SCAN at count SCAN_DIV-1 with any row_s bit low: latch c and the lowest-indexed low row r, clear the debounce counter, enter PRESS_DB; lowest row index wins on multiple simultaneous presses.
REQ-015 PRESS_DB: col_drive held on the latched column; debounce counter increments each cycle row_s[r] is low; if row_s[r] goes high, return to SCAN with c advanced by one and no output change.
REQ-016 PRESS_DB with counter reaching DEBOUNCE_CNT: enter PRESSED; in that same transition keypad <= {r,c}, key_held <= 1, key_valid <= 1 for exactly one cycle.
REQ-017 PRESSED: col_drive held; keypad and key_held stable; when row_s[r] goes high, clear the debounce counter and enter RELEASE_DB; presses on other keys SHALL be ignored.
REQ-018 RELEASE_DB: counter increments each cycle row_s[r] is high; if row_s[r] goes low, return to PRESSED with no new key_valid.
REQ-019 RELEASE_DB with counter reaching DEBOUNCE_CNT: keypad <= IDLE_CODE, key_held <= 0, enter SCAN at column (c+1) mod 4 with dwell counter cleared.
REQ-020 key_valid SHALL never be high in two consecutive cycles; at most one pulse per accepted press.
REQ-021 Dwell and debounce counters SHALL be 16 bits and never wrap; they saturate at their terminal value.
REQ-022 All outputs SHALL be registered; no combinational path from row_sense to any output.

Reset
REQ-023 rst_n low SHALL immediately and asynchronously set: state SCAN, c = 0, col_drive = 4'b1110, keypad = IDLE_CODE, key_valid = 0, key_held = 0, all counters and synchronizer flops cleared (synchronizer to 4'b1111).
REQ-024 Reset asserted in any state, including mid-debounce or with a key held, SHALL discard the press; after release, a still-held key requires a full scan and PRESS_DB before acceptance.
REQ-025 The first scan after rst_n rises SHALL start at column 0, dwell count 0.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8, IDLE_CODE=0)
REQ-026 No key, 20 cycles after reset -> col_drive cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid never high.
REQ-027 Hold row 2 low while column 1 is driven, stable 40 cycles -> key_valid one pulse, keypad = 4'b1001, key_held = 1 until release debounce completes, then keypad = 0.
REQ-028 Key 0011 (row 0, col 3) with 3-cycle bounce glitches during press and release -> exactly one key_valid, keypad = 0011 held, no extra pulse on release-bounce.
REQ-029 Rows 1 and 3 low simultaneously on column 0 -> keypad = 4'b0100 (row 1 wins).
REQ-030 rst_n pulled low during PRESSED with keypad = 1100 -> outputs return to reset values immediately, col_drive = 1110; with key still held after reset, re-acceptance occurs only after full scan plus 8 debounce cycles.
